permutation_engine: RTL and testbench
=====================================

Name: permutation_engine

Overview:
Runtime-programmable, parametrised bit-permutation unit for the SDES datapath. One block covers all fixed permutations: IP, IP^-1, P10, P8 (with WIDTH trimming), P4 and EP-style reorders. A forward map is loaded serially and validated by a scan FSM, which also builds the inverse map in hardware. Each data beat selects forward or inverse mode and passes through a one-stage valid/ready pipeline register.

Parameters:
WIDTH, 8, data width in bits and number of map entries (2..64).
IDX_W, $clog2(WIDTH), index width; derived, not overridden.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_valid  in  1  input beat valid
o_ready  out  1  block can accept input beat
i_mode  in  1  0 = forward map, 1 = inverse map; sampled with the beat
i_data  in  WIDTH  input data
o_valid  out  1  output beat valid
i_ready  in  1  downstream accepts output
o_data  out  WIDTH  permuted data
i_cfg_we  in  1  write shadow map entry
i_cfg_idx  in  IDX_W  output bit index k
i_cfg_src  in  IDX_W  source input bit for output bit k
i_cfg_commit  in  1  start validate/apply of shadow map
o_cfg_busy  out  1  scan in progress
o_cfg_done  out  1  one-cycle pulse when scan finishes
o_cfg_err  out  1  sticky: last commit rejected

Behaviour:
- Reset (synchronous, i_rst=1 at edge):
  - Active forward map, inverse map and shadow map all set to identity (map[k]=k).
  - o_valid=0, o_data=0, o_cfg_busy=0, o_cfg_done=0, o_cfg_err=0, FSM to IDLE.
  - Reset mid-scan aborts the scan and discards the shadow contents.
- Datapath:
  - Forward: o_data[k] = i_data[fwd[k]].
  - Inverse: o_data[k] = i_data[inv[k]], where inv[fwd[k]] = k.
  - o_ready = !o_valid || i_ready.
  - Beat accepted when i_valid && o_ready; result registered, appears with latency 1.
  - o_data/o_valid held stable while o_valid && !i_ready.
  - Full throughput: one beat per cycle when i_ready=1.
  - The datapath always uses the active maps; it never stalls for config, and beats flow during a scan using the old maps.
- Shadow map write:
  - When i_cfg_we and FSM in IDLE: shadow[i_cfg_idx] <= i_cfg_src.
  - Writes with i_cfg_idx >= WIDTH are ignored.
  - Writes while busy are ignored.
- FSM IDLE -> SCAN -> APPLY -> IDLE:
  - IDLE: i_cfg_commit=1 -> SCAN. Same-cycle i_cfg_we is written first and is included in the scan. o_cfg_err clears on commit.
  - SCAN: k = 0..WIDTH-1, one entry per cycle.
    - Error if shadow[k] >= WIDTH or seen[shadow[k]] already set.
    - Otherwise set seen[shadow[k]] and tmp_inv[shadow[k]] <= k.
    - Lasts exactly WIDTH cycles.
  - APPLY: one cycle.
    - If no error: fwd <= shadow, inv <= tmp_inv, taking effect for beats accepted from the next cycle.
    - If error: active maps unchanged, o_cfg_err <= 1.
    - o_cfg_done=1 in this cycle. Then -> IDLE.
- o_cfg_busy=1 in SCAN and APPLY (WIDTH+1 cycles per commit).
- i_cfg_commit while busy is ignored.
- The seen vector clears on entering SCAN.

Test Plan:
- Reset, then beats in both modes -> identity: 0xA5 -> 0xA5 and 0x3C -> 0x3C; o_cfg_err=0; o_valid=0 on the cycle after reset.
- Load the SDES IP^-1 map (k7..k0 sources = 4,7,5,3,1,6,0,2) and commit.
  - Required: busy for exactly 9 cycles, done pulse, err=0.
  - Forward: 0x80 -> 0x40 and 0x01 -> 0x02.
  - Inverse: 0x40 -> 0x80 and 0x02 -> 0x01, i.e. forward then inverse round-trips.
- Duplicate map (shadow[0]=2, shadow[1]=2, rest identity), commit -> done pulse, err=1; active stays identity (0xA5 -> 0xA5); next valid commit clears err.
- Backpressure: stream 4 beats with i_ready low for 3 cycles mid-stream -> o_data stable, o_ready low while stalled, no beat lost or duplicated, order preserved.
- Beats streaming during a scan:
  - Beats accepted up to and including the APPLY cycle use the old map.
  - Beats accepted on the cycle after APPLY use the new map.
  - Writes and commits during the scan are ignored.
- i_rst asserted at SCAN cycle 3 -> all maps identity, busy=0, no done pulse, o_valid=0.

Source files
------------

// File: rtl/permutation_engine.sv
// rtl/permutation_engine.sv - runtime-programmable bit permutation with scan-validated forward/inverse maps
module permutation_engine #(
    parameter int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_cfg_we,
    input  logic [IDX_W-1:0] i_cfg_idx,
    input  logic [IDX_W-1:0] i_cfg_src,
    input  logic             i_cfg_commit,
    output logic             o_cfg_busy,
    output logic             o_cfg_done,
    output logic             o_cfg_err
);
    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_APPLY} state_t;
    typedef logic [IDX_W-1:0] idx_t;

    state_t           state_q, state_d;
    idx_t             fwd_q [WIDTH];
    idx_t             fwd_d [WIDTH];
    idx_t             inv_q [WIDTH];
    idx_t             inv_d [WIDTH];
    idx_t             shadow_q [WIDTH];
    idx_t             shadow_d [WIDTH];
    idx_t             tmp_inv_q [WIDTH];
    idx_t             tmp_inv_d [WIDTH];
    logic [WIDTH-1:0] seen_q, seen_d;
    idx_t             scan_k_q, scan_k_d;
    logic             scan_err_q, scan_err_d;
    logic             cfg_err_q, cfg_err_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             accept;
    logic [WIDTH-1:0] perm_data;
    idx_t             scan_src;
    logic             scan_src_ok;

    function automatic logic idx_in_range(input idx_t v);
        return {1'b0, v} < (IDX_W+1)'(WIDTH);
    endfunction

    assign o_ready    = !out_valid_q || i_ready;
    assign accept     = i_valid && o_ready;
    assign o_valid    = out_valid_q;
    assign o_data     = out_data_q;
    assign o_cfg_busy = (state_q != ST_IDLE);
    assign o_cfg_done = (state_q == ST_APPLY);
    assign o_cfg_err  = cfg_err_q;

    // Datapath only ever reads the active maps, so config activity never stalls beats
    always_comb begin
        perm_data = '0;
        for (int k = 0; k < WIDTH; k++) begin
            perm_data[k] = i_data[i_mode ? inv_q[k] : fwd_q[k]];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = perm_data;
        end else if (i_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        fwd_d      = fwd_q;
        inv_d      = inv_q;
        shadow_d   = shadow_q;
        tmp_inv_d  = tmp_inv_q;
        seen_d     = seen_q;
        scan_k_d   = scan_k_q;
        scan_err_d = scan_err_q;
        cfg_err_d  = cfg_err_q;

        scan_src    = shadow_q[scan_k_q];
        scan_src_ok = idx_in_range(scan_src) && !seen_q[scan_src];

        case (state_q)
            ST_IDLE: begin
                // A write in the commit cycle lands before the scan reads the shadow map
                if (i_cfg_we && idx_in_range(i_cfg_idx)) begin
                    shadow_d[i_cfg_idx] = i_cfg_src;
                end
                if (i_cfg_commit) begin
                    state_d    = ST_SCAN;
                    scan_k_d   = '0;
                    seen_d     = '0;
                    scan_err_d = 1'b0;
                    cfg_err_d  = 1'b0;
                end
            end
            ST_SCAN: begin
                if (scan_src_ok) begin
                    seen_d[scan_src]    = 1'b1;
                    tmp_inv_d[scan_src] = scan_k_q;
                end else begin
                    scan_err_d = 1'b1;
                end
                if (scan_k_q == idx_t'(WIDTH-1)) begin
                    state_d = ST_APPLY;
                end else begin
                    scan_k_d = scan_k_q + 1'b1;
                end
            end
            ST_APPLY: begin
                if (scan_err_q) begin
                    cfg_err_d = 1'b1;
                end else begin
                    fwd_d = shadow_q;
                    inv_d = tmp_inv_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            seen_q      <= '0;
            scan_k_q    <= '0;
            scan_err_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < WIDTH; k++) begin
                fwd_q[k]     <= idx_t'(k);
                inv_q[k]     <= idx_t'(k);
                shadow_q[k]  <= idx_t'(k);
                tmp_inv_q[k] <= idx_t'(k);
            end
        end else begin
            state_q     <= state_d;
            seen_q      <= seen_d;
            scan_k_q    <= scan_k_d;
            scan_err_q  <= scan_err_d;
            cfg_err_q   <= cfg_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            fwd_q       <= fwd_d;
            inv_q       <= inv_d;
            shadow_q    <= shadow_d;
            tmp_inv_q   <= tmp_inv_d;
        end
    end
endmodule

// File: tb/tb_permutation_engine.sv
// tb/tb_permutation_engine.sv - self-checking bench for permutation_engine
module tb_permutation_engine;
    localparam int WIDTH = 8;
    localparam int IDX_W = $clog2(WIDTH);

    logic             i_clk = 1'b0;
    logic             i_rst, i_valid, o_ready, i_mode, o_valid, i_ready;
    logic [WIDTH-1:0] i_data, o_data;
    logic             i_cfg_we, i_cfg_commit, o_cfg_busy, o_cfg_done, o_cfg_err;
    logic [IDX_W-1:0] i_cfg_idx, i_cfg_src;

    permutation_engine #(.WIDTH(WIDTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_mode(i_mode), .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx),
        .i_cfg_src(i_cfg_src), .i_cfg_commit(i_cfg_commit), .o_cfg_busy(o_cfg_busy),
        .o_cfg_done(o_cfg_done), .o_cfg_err(o_cfg_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             m;
        logic [WIDTH-1:0] e;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pops = 0;
    int commit_cyc = -1000;
    int fwd_m [WIDTH];
    int sh_m [WIDTH];
    int pend_m [WIDTH];
    bit err_m = 1'b0;
    bit last_acc;
    logic [WIDTH-1:0] exp_q[$];
    vec_t tbl [11];
    int ip_map [WIDTH];
    int dup_map [WIDTH];
    int rev_map [WIDTH];
    logic [WIDTH-1:0] beats [4];
    logic [WIDTH-1:0] held;
    int n_busy, n_done, guard, bidx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit perm_ok(input int m [WIDTH]);
        int cnt [WIDTH];
        for (int k = 0; k < WIDTH; k++) cnt[k] = 0;
        for (int k = 0; k < WIDTH; k++) begin
            if (m[k] < 0 || m[k] >= WIDTH) return 1'b0;
            cnt[m[k]]++;
        end
        for (int k = 0; k < WIDTH; k++) if (cnt[k] != 1) return 1'b0;
        return 1'b1;
    endfunction

    // Inverse mode is modelled as a scatter through the forward map
    function automatic logic [WIDTH-1:0] model_out(input logic [WIDTH-1:0] d, input logic inv);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (inv) r[fwd_m[k]] = d[k];
            else     r[k] = d[fwd_m[k]];
        end
        return r;
    endfunction

    task automatic step();
        bit busy, do_pop, commit_now;
        logic [WIDTH-1:0] push_v;
        #1;
        busy = (cyc >= commit_cyc + 1) && (cyc <= commit_cyc + WIDTH + 1);
        check("o_valid", o_valid, exp_q.size() != 0);
        check("o_ready", o_ready, (exp_q.size() == 0) || i_ready);
        do_pop = (exp_q.size() != 0) && i_ready;
        if (do_pop) check("o_data", o_data, exp_q[0]);
        check("cfg_busy", o_cfg_busy, busy);
        check("cfg_done", o_cfg_done, cyc == commit_cyc + WIDTH + 1);
        check("cfg_err", o_cfg_err, err_m);
        last_acc = i_valid && ((exp_q.size() == 0) || i_ready);
        push_v = model_out(i_data, i_mode);
        commit_now = 1'b0;
        if (!busy) begin
            if (i_cfg_we && int'(i_cfg_idx) < WIDTH) sh_m[i_cfg_idx] = int'(i_cfg_src);
            if (i_cfg_commit) commit_now = 1'b1;
        end
        @(posedge i_clk);
        if (do_pop) begin
            void'(exp_q.pop_front());
            pops++;
        end
        if (last_acc) exp_q.push_back(push_v);
        if (cyc == commit_cyc + WIDTH + 1) begin
            if (perm_ok(pend_m)) fwd_m = pend_m;
            else err_m = 1'b1;
        end
        if (commit_now) begin
            pend_m = sh_m;
            commit_cyc = cyc;
            err_m = 1'b0;
        end
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_cfg_we = 1'b0;
        i_cfg_commit = 1'b0;
        @(posedge i_clk);
        exp_q.delete();
        for (int k = 0; k < WIDTH; k++) begin
            fwd_m[k] = k;
            sh_m[k] = k;
        end
        err_m = 1'b0;
        commit_cyc = -1000;
        cyc++;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic load_map(input int m [WIDTH], input bit commit_last);
        for (int k = 0; k < WIDTH; k++) begin
            i_cfg_we = 1'b1;
            i_cfg_idx = k[IDX_W-1:0];
            i_cfg_src = m[k][IDX_W-1:0];
            i_cfg_commit = commit_last && (k == WIDTH - 1);
            step();
        end
        i_cfg_we = 1'b0;
        i_cfg_commit = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int exp_err);
        n_busy = 0;
        n_done = 0;
        guard = 0;
        while (o_cfg_busy && guard < 40) begin
            n_busy++;
            if (o_cfg_done) n_done++;
            step();
            guard++;
        end
        check({nm, "_busy_cycles"}, n_busy, WIDTH + 1);
        check({nm, "_done_pulses"}, n_done, 1);
        check({nm, "_err"}, o_cfg_err, exp_err);
    endtask

    task automatic beat_check(input int i);
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_data = tbl[i].d;
        i_mode = tbl[i].m;
        step();
        i_valid = 1'b0;
        #1;
        check($sformatf("tbl%0d", i), o_data, tbl[i].e);
        step();
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_cfg_we = 1'b0;
        i_cfg_commit = 1'b0;
        guard = 0;
        while ((o_cfg_busy || exp_q.size() != 0) && guard < 40) begin
            step();
            guard++;
        end
        check("drain_bound", guard < 40, 1);
    endtask

    task automatic scan_round(input bit rand_map, input bit full_rate);
        int m [WIDTH];
        int j, tmp;
        for (int k = 0; k < WIDTH; k++) m[k] = rand_map ? int'($urandom_range(0, WIDTH - 1)) : k;
        if (!rand_map) begin
            for (int k = WIDTH - 1; k > 0; k--) begin
                j = int'($urandom_range(0, k));
                tmp = m[k];
                m[k] = m[j];
                m[j] = tmp;
            end
        end
        load_map(m, 1'b0);
        for (int t = 0; t < WIDTH + 6; t++) begin
            i_cfg_commit = (t == 0);
            i_cfg_we = 1'b0;
            if (t > 0 && t <= WIDTH + 1) begin
                i_cfg_we = 1'($urandom_range(0, 1));
                i_cfg_idx = IDX_W'($urandom_range(0, WIDTH - 1));
                i_cfg_src = IDX_W'($urandom_range(0, WIDTH - 1));
                i_cfg_commit = 1'($urandom_range(0, 1));
            end
            i_valid = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
            i_ready = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
            i_data = WIDTH'($urandom);
            i_mode = 1'($urandom_range(0, 1));
            step();
        end
        drain();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 8'hA5};
        tbl[1] = '{8'h3C, 1'b1, 8'h3C};
        tbl[2] = '{8'hA5, 1'b1, 8'hA5};
        tbl[3] = '{8'hA5, 1'b0, 8'hA5};
        tbl[4] = '{8'h5C, 1'b1, 8'h5C};
        tbl[5] = '{8'h80, 1'b0, 8'h40};
        tbl[6] = '{8'h01, 1'b0, 8'h02};
        tbl[7] = '{8'h40, 1'b1, 8'h80};
        tbl[8] = '{8'h02, 1'b1, 8'h01};
        tbl[9] = '{8'h5A, 1'b0, 8'h5A};
        tbl[10] = '{8'h96, 1'b1, 8'h96};
        ip_map = '{2, 0, 6, 1, 3, 5, 7, 4};
        for (int k = 0; k < WIDTH; k++) begin
            dup_map[k] = k;
            rev_map[k] = WIDTH - 1 - k;
        end
        dup_map[0] = 2;
        dup_map[1] = 2;

        i_rst = 1'b0; i_valid = 1'b0; i_mode = 1'b0; i_data = '0; i_ready = 1'b1;
        i_cfg_we = 1'b0; i_cfg_idx = '0; i_cfg_src = '0; i_cfg_commit = 1'b0;
        do_reset();
        #1;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data", o_data, 0);
        check("rst_err", o_cfg_err, 0);
        check("rst_busy", o_cfg_busy, 0);
        for (int i = 0; i <= 2; i++) beat_check(i);

        load_map(dup_map, 1'b1);
        wait_idle("dup", 1);
        for (int i = 3; i <= 4; i++) beat_check(i);

        load_map(ip_map, 1'b1);
        wait_idle("ipinv", 0);
        for (int i = 5; i <= 8; i++) beat_check(i);

        for (int i = 0; i < 4; i++) beats[i] = WIDTH'($urandom);
        pops = 0;
        bidx = 0;
        held = '0;
        for (int t = 0; t < 12; t++) begin
            i_ready = !(t >= 3 && t <= 5);
            i_valid = (bidx < 4);
            i_data = beats[(bidx < 4) ? bidx : 0];
            i_mode = 1'($urandom_range(0, 1));
            #1;
            if (t == 3) held = o_data;
            if (t == 4 || t == 5) begin
                check("bp_hold", o_data, held);
                check("bp_ready_low", o_ready, 0);
            end
            step();
            if (last_acc) bidx++;
        end
        check("bp_pops", pops, 4);
        drain();

        scan_round(1'b0, 1'b1);
        for (int r = 0; r < 6; r++) scan_round(r[0], 1'b0);

        load_map(rev_map, 1'b1);
        i_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            i_data = WIDTH'($urandom);
            step();
        end
        do_reset();
        #1;
        check("rst_scan_busy", o_cfg_busy, 0);
        check("rst_scan_valid", o_valid, 0);
        check("rst_scan_data", o_data, 0);
        check("rst_scan_done", o_cfg_done, 0);
        for (int t = 0; t < WIDTH + 3; t++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_data = WIDTH'($urandom);
            i_mode = 1'($urandom_range(0, 1));
            step();
        end
        drain();
        for (int i = 9; i <= 10; i++) beat_check(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
